// File: rtl/free_list_pkg.sv
// free_list_pkg: shared rename-stage types for the free list and branch-stack checkpoints.
package free_list_pkg;
  localparam int NUM_PHYS_REG = 64;
  localparam int NUM_ARCH_REG = 32;
  localparam int FL_PW = $clog2(NUM_PHYS_REG - NUM_ARCH_REG) + 1;
  typedef logic [5:0] PHYS_REG;
  typedef logic [FL_PW-1:0] FL_PTR;
endpackage

// File: rtl/free_list.sv
// free_list: circular FIFO of free physical tags, 2 pops and 2 pushes per cycle, head restore on mispredict.
module free_list
  import free_list_pkg::*;
#(
  parameter int NUM_PHYS = NUM_PHYS_REG,
  parameter int NUM_ARCH = NUM_ARCH_REG,
  localparam int DEPTH = NUM_PHYS - NUM_ARCH,
  localparam int PW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    haz_nDispatched,
  input  logic [1:0]    rob_nRetired,
  input  PHYS_REG [1:0] rob_retireTagOld,
  input  logic          br_fub_pred_wrong,
  input  logic [PW-1:0] bs_recov_head,
  output PHYS_REG [1:0] fl_freeRegs,
  output logic [1:0]    fl_nAvailable,
  output logic [PW-1:0] fl_head,
  output logic [PW-1:0] fl_count
);
  localparam int IW = PW - 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  PHYS_REG mem [DEPTH];
  logic [PW-1:0] head, tail, count, head_n, tail_n, diff, room;
  logic [IW-1:0] head_i1, tail_i1;
  logic [1:0] pops, pushes;
  // DEPTH is a power of two, so plain pointer addition wraps the index and toggles the wrap bit.
  always_comb begin
    count = tail - head;
    head_i1 = head[IW-1:0] + IW'(1);
    tail_i1 = tail[IW-1:0] + IW'(1);
    pops = count < PW'(haz_nDispatched) ? count[1:0] : haz_nDispatched;
    head_n = br_fub_pred_wrong ? bs_recov_head : head + PW'(pops);
    diff = tail - head_n;
    room = diff >= DEPTH_P ? '0 : DEPTH_P - diff;
    pushes = room < PW'(rob_nRetired) ? room[1:0] : rob_nRetired;
    tail_n = tail + PW'(pushes);
  end
  assign fl_freeRegs[0] = mem[head[IW-1:0]];
  assign fl_freeRegs[1] = mem[head_i1];
  assign fl_nAvailable = count >= PW'(2) ? 2'd2 : count[1:0];
  assign fl_head = head;
  assign fl_count = count;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= DEPTH_P;
      for (int i = 0; i < DEPTH; i++) mem[i] <= PHYS_REG'(NUM_ARCH + i);
    end else begin
      head <= head_n;
      tail <= tail_n;
      if (pushes != 2'd0) mem[tail[IW-1:0]] <= rob_retireTagOld[0];
      if (pushes == 2'd2) mem[tail_i1] <= rob_retireTagOld[1];
    end
  end
endmodule
